// File: rtl/gate16_pkg.sv
// Shared op codes, FSM states and the golden bitwise reference for the gate16 self-check engine.
package gate16_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_OR   = 2'b00;
  localparam op_t OP_AND  = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_NAND = 2'b11;

  // Widest operand the golden function handles; callers cast in and truncate out.
  localparam int unsigned MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_t;

  function automatic word_t golden(word_t a, word_t b, op_t op);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/gate16_walk_gen.sv
// Combinational walking-ones pattern: step k sets one more operand bit, pair order alternating.
module gate16_walk_gen
  import gate16_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 6
) (
  input  logic [STEP_W-1:0] i_step,
  output logic [WIDTH-1:0]  o_a,
  output logic [WIDTH-1:0]  o_b
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_first;
    logic w_second;
    // Bit pair i is filled at steps 2i+1 and 2i+2.
    assign w_first  = (i_step >= STEP_W'(2 * i + 1));
    assign w_second = (i_step >= STEP_W'(2 * i + 2));
    if (i % 2 == 0) begin : g_even
      assign o_a[i] = w_first;
      assign o_b[i] = w_second;
    end else begin : g_odd
      assign o_a[i] = w_second;
      assign o_b[i] = w_first;
    end
  end

endmodule

// File: rtl/gate16_bist.sv
// Stimulus/response engine: drives walking-ones operands into a bitwise gate and checks its output.
module gate16_bist
  import gate16_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned NSTEPS = 2 * WIDTH + 1,
  localparam int unsigned CW     = $clog2(NSTEPS + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_dut_a,
  output logic [WIDTH-1:0] o_dut_b,
  input  logic [WIDTH-1:0] i_dut_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CW-1:0]    o_err_count,
  output logic [CW-1:0]    o_fail_step,
  output logic [WIDTH-1:0] o_fail_out
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_step;
  logic [3:0]       r_settle;
  op_t              r_op;
  logic [WIDTH-1:0] r_dut_a;
  logic [WIDTH-1:0] r_dut_b;
  logic [CW-1:0]    r_err_count;
  logic [CW-1:0]    r_fail_step;
  logic [WIDTH-1:0] r_fail_out;

  logic [WIDTH-1:0] w_pat_a;
  logic [WIDTH-1:0] w_pat_b;
  logic [WIDTH-1:0] w_golden;
  logic             w_start_ok;
  logic             w_last;
  logic             w_mismatch;

  gate16_walk_gen #(
    .WIDTH  (WIDTH),
    .STEP_W (CW)
  ) u_walk_gen (
    .i_step (r_step),
    .o_a    (w_pat_a),
    .o_b    (w_pat_b)
  );

  assign w_start_ok = i_start && ((r_state == StIdle) || (r_state == StDone));
  assign w_last     = (r_step == CW'(2 * WIDTH));
  assign w_golden   = WIDTH'(golden(word_t'(r_dut_a), word_t'(r_dut_b), r_op));
  // Four-state compare so an X from the gate under test is treated as a failure.
  assign w_mismatch = (i_dut_out !== w_golden);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_nxt = StDrive;
      StDrive:  w_state_nxt = StSettle;
      StSettle: if (r_settle == 4'd0) w_state_nxt = StCheck;
      StCheck:  w_state_nxt = w_last ? StDone : StDrive;
      StDone:   if (i_start) w_state_nxt = StDrive;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step      <= '0;
      r_settle    <= '0;
      r_op        <= OP_OR;
      r_dut_a     <= '0;
      r_dut_b     <= '0;
      r_err_count <= '0;
      r_fail_step <= '0;
      r_fail_out  <= '0;
    end else begin
      if (w_start_ok) begin
        r_step      <= '0;
        r_op        <= i_op;
        r_err_count <= '0;
        r_fail_step <= '0;
        r_fail_out  <= '0;
      end
      if (r_state == StDrive) begin
        r_dut_a  <= w_pat_a;
        r_dut_b  <= w_pat_b;
        r_settle <= 4'(SETTLE - 1);
      end
      if ((r_state == StSettle) && (r_settle != 4'd0)) begin
        r_settle <= r_settle - 4'd1;
      end
      if (r_state == StCheck) begin
        if (w_mismatch) begin
          if (r_err_count != CW'(NSTEPS)) begin
            r_err_count <= r_err_count + CW'(1);
          end
          if (r_err_count == '0) begin
            r_fail_step <= r_step;
            r_fail_out  <= i_dut_out;
          end
        end
        if (!w_last) begin
          r_step <= r_step + CW'(1);
        end
      end
    end
  end

  assign o_dut_a     = r_dut_a;
  assign o_dut_b     = r_dut_b;
  assign o_busy      = (r_state == StDrive) || (r_state == StSettle) || (r_state == StCheck);
  assign o_done      = (r_state == StDone);
  assign o_pass      = (r_state == StDone) && (r_err_count == '0);
  assign o_err_count = r_err_count;
  assign o_fail_step = r_fail_step;
  assign o_fail_out  = r_fail_out;

endmodule

// File: tb/tb_gate16_bist.sv
// Randomized self-checking bench for gate16_bist against a step-by-step reference of the walk.
module tb_gate16_bist;

  localparam int W  = 16;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          start3;
  logic [1:0]    op;
  logic [1:0]    op3;
  logic [1:0]    dut_gate;
  logic [W-1:0]  stuck0;
  logic [W-1:0]  stuck1;

  logic [W-1:0]  a1, b1, out1, fout1;
  logic          busy1, done1, pass1;
  logic [CW-1:0] err1, fstep1;

  logic [W-1:0]  a2, b2, out2, fout2;
  logic          busy2, done2, pass2;
  logic [CW-1:0] err2, fstep2;

  logic [W-1:0]  a3, b3, out3, fout3;
  logic          busy3, done3, pass3;
  logic [CW-1:0] err3, fstep3;

  logic [W-1:0]  d2_0 = '0, d2_1 = '0, d2_2 = '0;
  logic [W-1:0]  d3_0 = '0, d3_1 = '0, d3_2 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] apply_op(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    case (o)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Gate under test for the SETTLE=1 engine: chosen gate with optional stuck bits.
  always_comb out1 = (apply_op(dut_gate, a1, b1) & ~stuck0) | stuck1;

  // OR gates with a 3-cycle output delay for the SETTLE=2 and SETTLE=3 engines.
  always @(posedge clk) begin
    d2_0 <= a2 | b2;
    d2_1 <= d2_0;
    d2_2 <= d2_1;
    d3_0 <= a3 | b3;
    d3_1 <= d3_0;
    d3_2 <= d3_1;
  end
  assign out2 = d2_2;
  assign out3 = d3_2;

  gate16_bist #(.WIDTH(W), .SETTLE(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
    .o_dut_a(a1), .o_dut_b(b1), .i_dut_out(out1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_count(err1), .o_fail_step(fstep1), .o_fail_out(fout1)
  );

  gate16_bist #(.WIDTH(W), .SETTLE(2)) u_dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(start3), .i_op(op3),
    .o_dut_a(a2), .o_dut_b(b2), .i_dut_out(out2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_count(err2), .o_fail_step(fstep2), .o_fail_out(fout2)
  );

  gate16_bist #(.WIDTH(W), .SETTLE(3)) u_dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start3), .i_op(op3),
    .o_dut_a(a3), .o_dut_b(b3), .i_dut_out(out3),
    .o_busy(busy3), .o_done(done3), .o_pass(pass3),
    .o_err_count(err3), .o_fail_step(fstep3), .o_fail_out(fout3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: replay the 33-step walk, compare gate response to the golden op.
  task automatic ref_run(input logic [1:0] run_op, input logic [1:0] gate,
                         input logic [W-1:0] s0, input logic [W-1:0] s1,
                         output int err, output int fstep, output logic [W-1:0] fout);
    logic [W-1:0] a, b, act, expv;
    int i;
    a = '0; b = '0; err = 0; fstep = 0; fout = '0;
    for (int k = 0; k <= 2 * W; k++) begin
      if (k > 0) begin
        i = (k - 1) / 2;
        if (((k % 2) == 1) == ((i % 2) == 0)) a[i] = 1'b1;
        else b[i] = 1'b1;
      end
      act  = (apply_op(gate, a, b) & ~s0) | s1;
      expv = apply_op(run_op, a, b);
      if (act != expv) begin
        if (err == 0) begin
          fstep = k;
          fout  = act;
        end
        err++;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy1), 64'd0);
    check_eq({tag, "_done"}, 64'(done1), 64'd0);
    check_eq({tag, "_pass"}, 64'(pass1), 64'd0);
    check_eq({tag, "_ab"}, 64'({a1, b1}), 64'd0);
    check_eq({tag, "_err"}, 64'(err1), 64'd0);
    check_eq({tag, "_fstep"}, 64'(fstep1), 64'd0);
    check_eq({tag, "_fout"}, 64'(fout1), 64'd0);
  endtask

  // Start a run on the SETTLE=1 engine, scramble op throughout, optionally re-pulse start.
  task automatic run1(input logic [1:0] run_op, input int pulse_at);
    int exp_err, exp_step, cyc;
    logic [W-1:0] exp_out;
    ref_run(run_op, dut_gate, stuck0, stuck1, exp_err, exp_step, exp_out);
    op    = run_op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy1), 64'd1);
    check_eq("done_cleared", 64'(done1), 64'd0);
    check_eq("err_cleared", 64'(err1), 64'd0);
    check_eq("fout_cleared", 64'(fout1), 64'd0);
    cyc = 0;
    while (!done1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      op    = 2'($urandom_range(0, 3));
      start = (cyc == pulse_at);
    end
    start = 1'b0;
    check_eq("run_cycles", 64'(cyc), 64'd99);
    check_eq("pass", 64'(pass1), 64'(exp_err == 0));
    check_eq("err_count", 64'(err1), 64'(exp_err));
    check_eq("fail_step", 64'(fstep1), 64'(exp_step));
    check_eq("fail_out", 64'(fout1), 64'(exp_out));
    check_eq("final_ab", 64'({a1, b1}), 64'h0000_0000_FFFF_FFFF);
    check_eq("busy_in_done", 64'(busy1), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [1:0] rop;
    reset = 1'b1; start = 1'b0; start3 = 1'b0; op = 2'd0; op3 = 2'd0;
    dut_gate = 2'd0; stuck0 = '0; stuck1 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    run1(2'd0, -1);                       // good OR
    stuck0 = W'(16'h0004);
    run1(2'd0, -1);                       // stuck-at-0 on bit 2, restart from DONE
    stuck0 = '0;
    run1(2'd1, -1);                       // OR gate against AND golden
    run1(2'd0, 10);                       // start re-pulsed mid-run

    // Reset in the middle of a run.
    op = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    // Reset and start together: reset wins.
    start = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_vs_start");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    run1(2'd0, -1);

    for (int n = 0; n < 8; n++) begin
      rop      = 2'($urandom_range(0, 3));
      dut_gate = ($urandom_range(0, 1) == 1) ? rop : 2'($urandom_range(0, 3));
      stuck0   = ($urandom_range(0, 2) == 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
      stuck1   = ($urandom_range(0, 2) == 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
      run1(rop, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 95)) : -1);
    end

    // Slow gate: SETTLE=3 covers the delay, SETTLE=2 sees each step one pattern late.
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("s3_cycles", 64'(cyc), 64'd165);
    check_eq("s3_pass", 64'(pass3), 64'd1);
    check_eq("s3_err", 64'(err3), 64'd0);
    check_eq("s2_done", 64'(done2), 64'd1);
    check_eq("s2_pass", 64'(pass2), 64'd0);
    check_eq("s2_fail_step", 64'(fstep2), 64'd1);
    check_eq("s2_err", 64'(err2), 64'd16);
    check_eq("s2_fail_out", 64'(fout2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
